// File: rtl/fifo_consumer.sv
// Burst drain engine: pops a programmed number of words from the FIFO and writes them to consecutive SRAM addresses.
// Latency: start -> WAIT next cycle; BURST one cycle later when the FIFO holds a full chunk; first SRAM write one cycle after the first pop.
// Backpressure: waits in WAIT until fifo_count covers the whole next chunk, so a burst never underflows; the SRAM side never stalls.
module fifo_consumer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 16,
    parameter int CNT_W     = 6,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  total_len,
    output logic              busy,
    output logic              done,
    input  logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    // Comparison width wide enough for both the remaining length and the FIFO count.
    localparam int CMP_W = (LEN_W > CNT_W) ? LEN_W : CNT_W;
    localparam logic [CMP_W-1:0] BURST_MAX = CMP_W'(BURST_LEN);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_WAIT   = 6'b000010,
        S_BURST  = 6'b000100,
        S_BDONE  = 6'b001000,
        S_BNDONE = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wen_q;
    logic [CMP_W-1:0]  remaining_ext;
    logic [CMP_W-1:0]  count_ext;
    logic [CMP_W-1:0]  chunk;
    logic              chunk_ready;

    // Size of the next burst and whether the FIFO already holds all of it.
    always_comb begin
        remaining_ext = CMP_W'(remaining);
        count_ext     = CMP_W'(fifo_count);
        chunk         = (remaining_ext < BURST_MAX) ? remaining_ext : BURST_MAX;
        chunk_ready   = (count_ext >= chunk);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (total_len == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (chunk_ready) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                fifo_rd_en = 1'b1;
                if (beat_cnt == CNT_W'(1)) begin
                    state_nxt = S_BDONE;
                end
            end
            S_BDONE: begin
                state_nxt = (remaining == '0) ? S_DONE : S_BNDONE;
            end
            S_BNDONE: begin
                state_nxt = S_WAIT;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, write pointer and the one-cycle delayed write strobe matching the FIFO read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            beat_cnt  <= '0;
            wr_ptr    <= '0;
            wen_q     <= 1'b0;
        end else begin
            wen_q <= fifo_rd_en;
            if (wen_q) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_ptr    <= base_addr;
                        remaining <= total_len;
                    end
                end
                S_WAIT: begin
                    if (chunk_ready) begin
                        beat_cnt <= chunk[CNT_W-1:0];
                    end
                end
                S_BURST: begin
                    beat_cnt  <= beat_cnt - CNT_W'(1);
                    remaining <= remaining - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Write data is only presented while the strobe is up so the bus idles at zero.
    assign mem_wen   = wen_q;
    assign mem_addr  = wr_ptr;
    assign mem_wdata = wen_q ? fifo_rd_data : '0;

endmodule

// File: tb/tb_fifo_consumer.sv
// Bench for fifo_consumer: behavioural FIFO, write monitor and a transfer-level reference model.
module tb_fifo_consumer;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int CW = 6;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] total_len = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] fifo_count;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_consumer #(
        .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .CNT_W(CW), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_len(total_len),
        .busy(busy), .done(done), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    // Behavioural FIFO with registered read data; reset flushes it.
    logic [DW-1:0] fmem [0:255];
    logic [7:0]    fwr = 8'd0;
    logic [7:0]    frd = 8'd0;
    int            uflow = 0;
    assign fifo_count = CW'(fwr - frd);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frd          <= fwr;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en) begin
            if (frd == fwr) uflow <= uflow + 1;
            fifo_rd_data <= fmem[frd];
            frd          <= frd + 8'd1;
        end
    end

    // Cycle counter and output monitor (sampled on the falling edge).
    int            cyc = 0;
    logic [AW-1:0] obs_a [$];
    logic [DW-1:0] obs_d [$];
    int            obs_c [$];
    int            rd_cnt = 0;
    int            burst_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            viol = 0;
    logic          prev_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (mem_wen !== prev_rd) viol++;
            if (fifo_rd_en && !busy) viol++;
            if (done && !busy) viol++;
            if (mem_wen) begin
                obs_a.push_back(mem_addr);
                obs_d.push_back(mem_wdata);
                obs_c.push_back(cyc);
            end
            if (fifo_rd_en) rd_cnt++;
            if (fifo_rd_en && !prev_rd) burst_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_rd = fifo_rd_en;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        fmem[fwr] = d;
        fwr = fwr + 8'd1;
    endtask

    // Cycles from start to the done pulse when the FIFO already holds every word.
    function automatic int exp_lat(input int len);
        int t;
        int rem;
        int ch;
        t   = 1;
        rem = len;
        while (rem > 0) begin
            ch  = (rem < BL) ? rem : BL;
            t   = t + ch + 2;
            rem = rem - ch;
            if (rem > 0) t = t + 1;
        end
        return t;
    endfunction

    // mode 0: FIFO preloaded; mode 1: FIFO trickle-fed; mode 2: one word short for 20 cycles.
    task automatic run_xfer(input logic [AW-1:0] base, input int len, input int mode, input int restart_at);
        logic [DW-1:0] exp_d [$];
        logic [AW-1:0] ea;
        int o0, rd0, b0, d0, v0, u0, s, pushed, budget;
        bit seen;
        for (int i = 0; i < len; i++) exp_d.push_back($urandom);
        pushed = 0;
        if (mode == 0) begin
            while (pushed < len) begin push(exp_d[pushed]); pushed++; end
        end else if (mode == 2) begin
            while (pushed < len - 1) begin push(exp_d[pushed]); pushed++; end
        end
        o0 = obs_a.size(); rd0 = rd_cnt; b0 = burst_cnt; d0 = done_cnt; v0 = viol; u0 = uflow;
        base_addr = base;
        total_len = LW'(len);
        start     = 1'b1;
        s         = cyc;
        tick;
        start     = 1'b0;
        base_addr = AW'($urandom);
        total_len = LW'($urandom);
        seen   = 1'b0;
        budget = 400 + 40 * len;
        for (int t = 1; t < budget && !seen; t++) begin
            start = 1'b0;
            if (mode == 1 && pushed < len && (fwr - frd) < 8'd60 && $urandom_range(0, 2) != 0) begin
                push(exp_d[pushed]);
                pushed++;
            end
            if (mode == 2 && t == 20) begin
                chk("hold_no_pop", 64'(rd_cnt - rd0), 64'd0);
                chk("hold_busy", 64'(busy), 64'd1);
                push(exp_d[pushed]);
                pushed++;
            end
            if (restart_at > 0 && t == restart_at) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                total_len = LW'($urandom_range(1, 60));
            end
            tick;
            if (done_cnt != d0) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        tick;
        tick;
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("n_writes", 64'(obs_a.size() - o0), 64'(len));
        chk("n_pops", 64'(rd_cnt - rd0), 64'(len));
        chk("n_bursts", 64'(burst_cnt - b0), 64'((len + BL - 1) / BL));
        for (int i = 0; i < len && (o0 + i) < obs_a.size(); i++) begin
            ea = base + AW'(i);
            chk("wr_addr", 64'(obs_a[o0 + i]), 64'(ea));
            chk("wr_data", 64'(obs_d[o0 + i]), 64'(exp_d[i]));
        end
        if (len > 0 && obs_c.size() >= o0 + len) begin
            chk("done_after_last_wr", 64'(done_cyc - obs_c[o0 + len - 1]), 64'd1);
            if (mode == 0) chk("first_wr_lat", 64'(obs_c[o0] - s), 64'd3);
        end
        if (mode == 0) chk("done_lat", 64'(done_cyc - s), 64'(exp_lat(len)));
        chk("invariants", 64'(viol - v0), 64'd0);
        chk("underflow", 64'(uflow - u0), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_wen"}, 64'(mem_wen), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    initial begin
        int s;
        int len;
        int mode;
        int rs;
        rst = 1'b1;
        repeat (3) tick;
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick;
        chk("idle_busy", 64'(busy), 64'd0);

        // Two full bursts, short wait-limited burst, zero length, address wrap.
        run_xfer(16'h0100, 16, 0, 0);
        run_xfer(16'h0040, 5, 2, 0);
        run_xfer(16'h0ABC, 0, 0, 0);
        run_xfer(16'hFFFC, 8, 0, 0);

        // Reset on the third beat of a burst, then a fresh transfer.
        for (int i = 0; i < 16; i++) push($urandom);
        base_addr = 16'h0200;
        total_len = 16'd16;
        start     = 1'b1;
        s         = cyc;
        tick;
        start = 1'b0;
        for (int t = 0; t < 50 && cyc < s + 4; t++) tick;
        chk("mid_burst_rd_en", 64'(fifo_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_busy", 64'(busy), 64'd0);
        run_xfer(16'h1234, 4, 0, 0);

        // Second start during an active transfer is ignored.
        run_xfer(16'h3000, 16, 0, 5);

        // Randomized transfers.
        for (int n = 0; n < 8; n++) begin
            len  = $urandom_range(1, 40);
            mode = $urandom_range(0, 1);
            rs   = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 3) : 0;
            run_xfer(AW'($urandom), len, mode, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
